// File: rtl/reduce_combine_ctrl.sv
// Reduction-tree combine node: merges child flits per context into one uptree result flit.
// Latency: 1 cycle from the completing accept to out_valid.
// Backpressure: in_ready drops while a result is held and out_ready is low; the pending result is held stable.
//
// Ports:
//   clk        single clock, all state on the rising edge
//   rst        asynchronous active-low reset (release synchronous to clk)
//   in_flit    76-bit input flit {children, valid, dst, src, ctx, tag, algtype, op, payload}
//   in_valid   input flit offered; in_ready accepts it
//   out_flit   73-bit combined result {valid, dst, src, ctx, tag, algtype, op, payload}
//   out_valid  result valid; out_ready accepts it
//   err        one-cycle pulse for every dropped flit
//   busy       per-entry open flags of the 4-entry context table
module reduce_combine_ctrl #(
  parameter logic [2:0] RANK_X   = 3'b0,
  parameter logic [2:0] RANK_Y   = 3'b0,
  parameter logic [2:0] RANK_Z   = 3'b0,
  parameter logic [2:0] PARENT_X = 3'b0,
  parameter logic [2:0] PARENT_Y = 3'b0,
  parameter logic [2:0] PARENT_Z = 3'b0,
  parameter bit         IS_ROOT  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [75:0] in_flit,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [72:0] out_flit,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        err,
  output logic [3:0]  busy
);

  localparam logic [8:0] SRC_COORD = {RANK_X, RANK_Y, RANK_Z};
  // The root of the tree addresses its result to itself.
  localparam logic [8:0] DST_COORD = IS_ROOT ? SRC_COORD : {PARENT_X, PARENT_Y, PARENT_Z};

  localparam logic [3:0] OP_SUM = 4'd0;
  localparam logic [3:0] OP_MAX = 4'd1;
  localparam logic [3:0] OP_MIN = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;

  // Input flit fields
  logic [2:0]  f_children;
  logic        f_vld;
  logic [7:0]  f_ctx;
  logic [7:0]  f_tag;
  logic [1:0]  f_alg;
  logic [3:0]  f_op;
  logic [31:0] f_pay;

  assign f_children = in_flit[75:73];
  assign f_vld      = in_flit[72];
  assign f_ctx      = in_flit[53:46];
  assign f_tag      = in_flit[45:38];
  assign f_alg      = in_flit[37:36];
  assign f_op       = in_flit[35:32];
  assign f_pay      = in_flit[31:0];

  // Incoming routing fields are replaced by this node's own coordinates.
  logic unused_route;
  assign unused_route = ^in_flit[71:54];

  // Context table
  logic [3:0]  ent_open;
  logic [3:0]  ent_rem [4];
  logic [31:0] ent_acc [4];
  logic [3:0]  ent_op  [4];
  logic [1:0]  ent_alg [4];
  logic [7:0]  ent_tag [4];
  logic [7:0]  ent_ctx [4];

  function automatic logic [31:0] combine(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    case (op)
      OP_SUM:  r = a + b;
      OP_MAX:  r = (a > b) ? a : b;
      OP_MIN:  r = (a < b) ? a : b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = a;
    endcase
    return r;
  endfunction

  logic        accept;
  logic [1:0]  idx;
  logic        op_ok;
  logic        hit_open;
  logic        key_match;
  logic        drop;
  logic        do_open;
  logic        do_comb;
  logic [3:0]  rem_next;
  logic [31:0] comb_acc;
  logic        complete;
  logic [31:0] res_acc;
  logic [1:0]  res_alg;

  // A held result only blocks input when downstream is not draining it this cycle.
  assign in_ready = rst & (~out_valid | out_ready);

  assign accept    = in_valid & in_ready & f_vld;
  assign idx       = f_ctx[1:0];
  assign op_ok     = (f_op <= OP_XOR);
  assign hit_open  = ent_open[idx];
  // Entries are indexed by ctx[1:0] only, so the full context must also agree.
  assign key_match = (ent_ctx[idx] == f_ctx) && (ent_tag[idx] == f_tag) && (ent_op[idx] == f_op);

  assign drop    = accept & (~op_ok | (hit_open & ~key_match));
  assign do_open = accept & op_ok & ~hit_open;
  assign do_comb = accept & op_ok & hit_open & key_match;

  assign rem_next = ent_rem[idx] - 4'd1;
  assign comb_acc = combine(f_op, ent_acc[idx], f_pay);

  // Leaf flits complete immediately; otherwise the last outstanding child completes.
  assign complete = (do_open & (f_children == 3'd0)) | (do_comb & (rem_next == 4'd0));
  assign res_acc  = do_open ? f_pay : comb_acc;
  assign res_alg  = do_open ? f_alg : ent_alg[idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_open <= '0;
      for (int k = 0; k < 4; k++) begin
        ent_rem[k] <= '0;
        ent_acc[k] <= '0;
        ent_op[k]  <= '0;
        ent_alg[k] <= '0;
        ent_tag[k] <= '0;
        ent_ctx[k] <= '0;
      end
    end else if (do_open) begin
      ent_open[idx] <= (f_children != 3'd0);
      ent_rem[idx]  <= {1'b0, f_children};
      ent_acc[idx]  <= f_pay;
      ent_op[idx]   <= f_op;
      ent_alg[idx]  <= f_alg;
      ent_tag[idx]  <= f_tag;
      ent_ctx[idx]  <= f_ctx;
    end else if (do_comb) begin
      ent_acc[idx] <= comb_acc;
      ent_rem[idx] <= rem_next;
      if (rem_next == 4'd0) begin
        ent_open[idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_flit  <= '0;
      err       <= 1'b0;
    end else begin
      err <= drop;
      // complete can only occur when in_ready is high, i.e. the output slot is free or draining.
      if (complete) begin
        out_valid <= 1'b1;
        out_flit  <= {1'b1, DST_COORD, SRC_COORD, f_ctx, f_tag, res_alg, f_op, res_acc};
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy = ent_open;

endmodule

// File: tb/tb_reduce_combine_ctrl.sv
module tb_reduce_combine_ctrl;

  localparam logic [2:0] RX = 3'd1, RY = 3'd2, RZ = 3'd3;
  localparam logic [2:0] PX = 3'd4, PY = 3'd5, PZ = 3'd6;
  localparam logic [1:0] ALG = 2'b10;
  localparam logic [8:0] IN_DST = 9'h1AB;
  localparam logic [8:0] IN_SRC = 9'h0CD;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [75:0] in_flit = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [72:0] out_flit;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        err;
  logic [3:0]  busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reduce_combine_ctrl #(
    .RANK_X(RX), .RANK_Y(RY), .RANK_Z(RZ),
    .PARENT_X(PX), .PARENT_Y(PY), .PARENT_Z(PZ),
    .IS_ROOT(1'b0)
  ) dut (
    .clk(clk), .rst(rst),
    .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
    .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready),
    .err(err), .busy(busy)
  );

  typedef struct {
    logic        iv;
    logic        fv;
    logic [2:0]  ch;
    logic [7:0]  ctx;
    logic [7:0]  tag;
    logic [3:0]  op;
    logic [31:0] pay;
    logic        ordy;
    logic        e_rdy;
    logic        e_ov;
    logic [7:0]  e_ctx;
    logic [7:0]  e_tag;
    logic [3:0]  e_op;
    logic [31:0] e_pay;
    logic        e_err;
    logic [3:0]  e_busy;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mkv(input logic iv, input logic fv, input logic [2:0] ch,
                               input logic [7:0] ctx, input logic [7:0] tag, input logic [3:0] op,
                               input logic [31:0] pay, input logic ordy, input logic e_rdy,
                               input logic e_ov, input logic [7:0] e_ctx, input logic [7:0] e_tag,
                               input logic [3:0] e_op, input logic [31:0] e_pay, input logic e_err,
                               input logic [3:0] e_busy);
    vec_t v;
    v.iv = iv; v.fv = fv; v.ch = ch; v.ctx = ctx; v.tag = tag; v.op = op; v.pay = pay;
    v.ordy = ordy; v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_ctx = e_ctx; v.e_tag = e_tag;
    v.e_op = e_op; v.e_pay = e_pay; v.e_err = e_err; v.e_busy = e_busy;
    return v;
  endfunction

  function automatic logic [75:0] mk_flit(input logic [2:0] ch, input logic fv, input logic [7:0] ctx,
                                          input logic [7:0] tag, input logic [3:0] op, input logic [31:0] pay);
    return {ch, fv, IN_DST, IN_SRC, ctx, tag, ALG, op, pay};
  endfunction

  function automatic logic [72:0] exp_flit(input logic [7:0] ctx, input logic [7:0] tag,
                                           input logic [3:0] op, input logic [31:0] pay);
    return {1'b1, PX, PY, PZ, RX, RY, RZ, ctx, tag, ALG, op, pay};
  endfunction

  task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic fv, input logic [2:0] ch, input logic [7:0] ctx,
                       input logic [7:0] tag, input logic [3:0] op, input logic [31:0] pay, input logic ordy);
    in_valid  = iv;
    in_flit   = mk_flit(ch, fv, ctx, tag, op, pay);
    out_ready = ordy;
  endtask

  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    drive(v.iv, v.fv, v.ch, v.ctx, v.tag, v.op, v.pay, v.ordy);
    #1;
    chk({name, "_in_ready"}, 73'(in_ready), 73'(v.e_rdy));
    @(posedge clk);
    #1;
    chk({name, "_out_valid"}, 73'(out_valid), 73'(v.e_ov));
    chk({name, "_err"}, 73'(err), 73'(v.e_err));
    chk({name, "_busy"}, 73'(busy), 73'(v.e_busy));
    if (v.e_ov) chk({name, "_out_flit"}, out_flit, exp_flit(v.e_ctx, v.e_tag, v.e_op, v.e_pay));
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, "_in_ready"}, 73'(in_ready), 73'(1'b0));
    chk({name, "_out_valid"}, 73'(out_valid), 73'(1'b0));
    chk({name, "_out_flit"}, out_flit, 73'(0));
    chk({name, "_err"}, 73'(err), 73'(1'b0));
    chk({name, "_busy"}, 73'(busy), 73'(4'b0000));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    // iv fv ch ctx tag op pay ordy | rdy ov ectx etag eop epay err busy
    vq.push_back(mkv(1'b1,1'b1,3'd0,8'h01,8'h11,4'd0,32'd7,1'b1, 1'b1,1'b1,8'h01,8'h11,4'd0,32'd7,1'b0,4'b0000)); // leaf SUM
    vq.push_back(mkv(1'b1,1'b1,3'd3,8'h00,8'h22,4'd0,32'd5,1'b1, 1'b1,1'b0,8'h00,8'h00,4'd0,32'd0,1'b0,4'b0001)); // 3-child SUM
    vq.push_back(mkv(1'b1,1'b1,3'd0,8'h00,8'h22,4'd0,32'd10,1'b1, 1'b1,1'b0,8'h00,8'h00,4'd0,32'd0,1'b0,4'b0001));
    vq.push_back(mkv(1'b1,1'b1,3'd0,8'h00,8'h22,4'd0,32'd20,1'b1, 1'b1,1'b0,8'h00,8'h00,4'd0,32'd0,1'b0,4'b0001));
    vq.push_back(mkv(1'b1,1'b1,3'd0,8'h00,8'h22,4'd0,32'd40,1'b1, 1'b1,1'b1,8'h00,8'h22,4'd0,32'd75,1'b0,4'b0000));
    vq.push_back(mkv(1'b1,1'b1,3'd1,8'h02,8'h33,4'd1,32'hFFFF0000,1'b1, 1'b1,1'b0,8'h00,8'h00,4'd0,32'd0,1'b0,4'b0100)); // MAX/MIN interleave
    vq.push_back(mkv(1'b1,1'b1,3'd1,8'h03,8'h44,4'd2,32'd8,1'b1, 1'b1,1'b0,8'h00,8'h00,4'd0,32'd0,1'b0,4'b1100));
    vq.push_back(mkv(1'b1,1'b1,3'd0,8'h02,8'h33,4'd1,32'd1,1'b1, 1'b1,1'b1,8'h02,8'h33,4'd1,32'hFFFF0000,1'b0,4'b1000));
    vq.push_back(mkv(1'b1,1'b1,3'd0,8'h03,8'h44,4'd2,32'd3,1'b1, 1'b1,1'b1,8'h03,8'h44,4'd2,32'd3,1'b0,4'b0000));
    for (int k = 0; k < 5; k++) // held result under backpressure
      vq.push_back(mkv(1'b1,1'b1,3'd0,8'h01,8'h55,4'd3,32'hF0,1'b0, 1'b0,1'b1,8'h03,8'h44,4'd2,32'd3,1'b0,4'b0000));
    vq.push_back(mkv(1'b1,1'b1,3'd0,8'h01,8'h55,4'd3,32'hF0,1'b1, 1'b1,1'b1,8'h01,8'h55,4'd3,32'hF0,1'b0,4'b0000)); // drain + new
    vq.push_back(mkv(1'b1,1'b1,3'd2,8'h02,8'h66,4'd5,32'hFF,1'b1, 1'b1,1'b0,8'h00,8'h00,4'd0,32'd0,1'b0,4'b0100)); // XOR + errors
    vq.push_back(mkv(1'b1,1'b1,3'd0,8'h02,8'h66,4'd5,32'h0F,1'b1, 1'b1,1'b0,8'h00,8'h00,4'd0,32'd0,1'b0,4'b0100));
    vq.push_back(mkv(1'b1,1'b1,3'd0,8'h02,8'h66,4'd9,32'h0,1'b1, 1'b1,1'b0,8'h00,8'h00,4'd0,32'd0,1'b1,4'b0100));
    vq.push_back(mkv(1'b1,1'b1,3'd0,8'h02,8'h67,4'd5,32'h123,1'b1, 1'b1,1'b0,8'h00,8'h00,4'd0,32'd0,1'b1,4'b0100));
    vq.push_back(mkv(1'b1,1'b1,3'd0,8'h02,8'h66,4'd5,32'hF0000000,1'b1, 1'b1,1'b1,8'h02,8'h66,4'd5,32'hF00000F0,1'b0,4'b0000));
    vq.push_back(mkv(1'b1,1'b1,3'd0,8'h01,8'h88,4'd4,32'hA,1'b1, 1'b1,1'b1,8'h01,8'h88,4'd4,32'hA,1'b0,4'b0000)); // leaf OR
    vq.push_back(mkv(1'b1,1'b0,3'd0,8'h00,8'h99,4'd0,32'd5,1'b1, 1'b1,1'b0,8'h00,8'h00,4'd0,32'd0,1'b0,4'b0000)); // flit valid bit low
    vq.push_back(mkv(1'b0,1'b1,3'd0,8'h00,8'h99,4'd0,32'd5,1'b1, 1'b1,1'b0,8'h00,8'h00,4'd0,32'd0,1'b0,4'b0000)); // in_valid low
    vq.push_back(mkv(1'b1,1'b1,3'd1,8'h00,8'h77,4'd3,32'hFF00FF00,1'b1, 1'b1,1'b0,8'h00,8'h00,4'd0,32'd0,1'b0,4'b0001)); // AND
    vq.push_back(mkv(1'b1,1'b1,3'd0,8'h00,8'h77,4'd3,32'h0FF00FF0,1'b1, 1'b1,1'b1,8'h00,8'h77,4'd3,32'h0F000F00,1'b0,4'b0000));
    vq.push_back(mkv(1'b1,1'b1,3'd1,8'h01,8'h12,4'd0,32'hFFFFFFFF,1'b1, 1'b1,1'b0,8'h00,8'h00,4'd0,32'd0,1'b0,4'b0010)); // SUM wrap
    vq.push_back(mkv(1'b1,1'b1,3'd0,8'h01,8'h12,4'd0,32'd2,1'b1, 1'b1,1'b1,8'h01,8'h12,4'd0,32'd1,1'b0,4'b0000));
    vq.push_back(mkv(1'b1,1'b1,3'd0,8'h00,8'h13,4'd6,32'd0,1'b1, 1'b1,1'b0,8'h00,8'h00,4'd0,32'd0,1'b1,4'b0000)); // op 6 on closed
    vq.push_back(mkv(1'b0,1'b0,3'd0,8'h00,8'h00,4'd0,32'd0,1'b1, 1'b1,1'b0,8'h00,8'h00,4'd0,32'd0,1'b0,4'b0000));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vq.size(); i++) apply(vq[i], $sformatf("v%0d", i));

    // Reset mid-reduction with a pending output
    apply(mkv(1'b1,1'b1,3'd3,8'h00,8'h21,4'd0,32'd1,1'b1, 1'b1,1'b0,8'h00,8'h00,4'd0,32'd0,1'b0,4'b0001), "mr_open");
    apply(mkv(1'b1,1'b1,3'd0,8'h00,8'h21,4'd0,32'd2,1'b1, 1'b1,1'b0,8'h00,8'h00,4'd0,32'd0,1'b0,4'b0001), "mr_comb");
    apply(mkv(1'b1,1'b1,3'd0,8'h01,8'h31,4'd0,32'd3,1'b0, 1'b1,1'b1,8'h01,8'h31,4'd0,32'd3,1'b0,4'b0001), "mr_pend");
    @(negedge clk);
    drive(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 4'd0, 32'd0, 1'b0);
    rst = 1'b0;
    #1;
    chk_reset_state("mr_rst_async");
    @(posedge clk);
    #1;
    chk_reset_state("mr_rst_held");
    @(negedge clk);
    rst = 1'b1;
    apply(mkv(1'b1,1'b1,3'd0,8'h00,8'h41,4'd0,32'd9,1'b1, 1'b1,1'b1,8'h00,8'h41,4'd0,32'd9,1'b0,4'b0000), "mr_leaf");
    apply(mkv(1'b0,1'b0,3'd0,8'h00,8'h00,4'd0,32'd0,1'b1, 1'b1,1'b0,8'h00,8'h00,4'd0,32'd0,1'b0,4'b0000), "mr_idle");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
